// File: rtl/accumulator_datapath_pkg.sv
// Shared constants and types for the accumulator CPU datapath and its control unit.
package accumulator_datapath_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [1:0] {
    BUS_MEM = 2'd0,
    BUS_DR  = 2'd1,
    BUS_PC  = 2'd2,
    BUS_AC  = 2'd3
  } bus_sel_e;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_JMP   = 3'd4,
    OP_JEQ   = 3'd5
  } opcode_e;

  // Instruction word layout: opcode in the top bits, operand address below.
  typedef struct packed {
    opcode_e                   op;
    logic [DATA_W-OP_W-1:0]    addr;
  } instr_t;

endpackage

// File: rtl/accumulator_datapath_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface accumulator_datapath_if
  import accumulator_datapath_pkg::*;
#(
  parameter int unsigned W  = DATA_W,
  parameter int unsigned AW = ADDR_W
);

  logic          ARLoad;
  logic          DRLoad;
  logic          PCLoad;
  logic          ACLoad;
  logic          IRLoad;
  logic          ALUSel;
  logic          PCInc;
  logic          memRW;
  logic [1:0]    BusSel;
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [W-1:0]  LD_DATA;
  logic [2:0]    IR;
  logic          Z;
  logic [W-1:0]  AC_OUT;
  logic [AW-1:0] PC_OUT;

  modport master (
    output ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, ALUSel, PCInc, memRW, BusSel,
    output LD_EN, LD_ADDR, LD_DATA,
    input  IR, Z, AC_OUT, PC_OUT
  );

  modport slave (
    input  ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, ALUSel, PCInc, memRW, BusSel,
    input  LD_EN, LD_ADDR, LD_DATA,
    output IR, Z, AC_OUT, PC_OUT
  );

endinterface

// File: rtl/accumulator_datapath_ram.sv
// Word RAM with asynchronous read and a single write port shared by the program
// loader and the CPU store path; writes are blocked while in reset.
module accumulator_datapath_ram
  import accumulator_datapath_pkg::*;
#(
  parameter int unsigned W  = DATA_W,
  parameter int unsigned AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  cpu_data,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;

  // Loader has priority over a CPU store in the same cycle.
  always_comb begin
    we    = rst_n & (ld_en | cpu_we);
    waddr = ld_en ? ld_addr : addr;
    wdata = ld_en ? ld_data : cpu_data;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/accumulator_datapath.sv
// Accumulator CPU datapath: AR/PC/DR/AC/IR registers, 4-source bus, add/sub ALU
// and word RAM. Sequencing is owned entirely by the external control unit.
module accumulator_datapath
  import accumulator_datapath_pkg::*;
#(
  parameter int unsigned W  = DATA_W,
  parameter int unsigned AW = ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  accumulator_datapath_if.slave  dp
);

  logic [AW-1:0] ar;
  logic [AW-1:0] pc;
  logic [W-1:0]  dr;
  logic [W-1:0]  ac;
  logic [2:0]    ir;
  logic [W-1:0]  bus;
  logic [W-1:0]  alu;
  logic [W-1:0]  mem_rd;

  // Bus is driven from pre-edge register values, so a register may drive and load in one cycle.
  always_comb begin
    bus = '0;
    unique case (bus_sel_e'(dp.BusSel))
      BUS_MEM: bus = mem_rd;
      BUS_DR:  bus = dr;
      BUS_PC:  bus = W'(pc);
      BUS_AC:  bus = ac;
    endcase
  end

  assign alu = dp.ALUSel ? (ac - bus) : (ac + bus);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ar <= '0;
      pc <= '0;
      dr <= '0;
      ac <= '0;
      ir <= '0;
    end else begin
      // ARLoad overrides the operand address that IRLoad would place in AR.
      if (dp.ARLoad)      ar <= AW'(bus);
      else if (dp.IRLoad) ar <= AW'(dr[W-4:0]);
      if (dp.IRLoad)      ir <= dr[W-1:W-3];
      if (dp.DRLoad)      dr <= bus;
      if (dp.PCLoad)      pc <= AW'(bus);
      else if (dp.PCInc)  pc <= pc + AW'(1);
      if (dp.ACLoad)      ac <= alu;
    end
  end

  accumulator_datapath_ram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk      (CLK),
    .rst_n    (RESETn),
    .ld_en    (dp.LD_EN),
    .ld_addr  (dp.LD_ADDR),
    .ld_data  (dp.LD_DATA),
    .cpu_we   (~dp.memRW),
    .addr     (ar),
    .cpu_data (bus),
    .rdata    (mem_rd)
  );

  assign dp.IR     = ir;
  assign dp.Z      = (ac == '0);
  assign dp.AC_OUT = ac;
  assign dp.PC_OUT = pc;

endmodule
